aviasales_rr: RTL

- Parametrised seat-reservation engine, successor of the single-desk booking block.
- Serves NCH sales channels, each issuing book/cancel requests, against a SEATS-entry occupancy bitmap.
- Channels are arbitrated round-robin and get a per-request ack/nack with a status code.
- Sits between the debounced button/PMOD input logic and the 7-segment display driver; free_cnt feeds the display.

---
 rtl/aviasales_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/aviasales_rr.sv | 137 +++++++++++++
 3 files changed

// File: rtl/aviasales_pkg.sv
// aviasales_pkg: shared status codes, operation codes and FSM encoding for the seat-reservation engine
package aviasales_pkg;
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TAKEN   = 2'd1;
    localparam logic [1:0] ST_CLOSED  = 2'd2;
    localparam logic [1:0] ST_BADSEAT = 2'd3;
    localparam logic OP_BOOK   = 1'b0;
    localparam logic OP_CANCEL = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending channel after ptr
module rr_arbiter
    import aviasales_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] pend,
    input  logic [2:0]   ptr,
    output logic [N-1:0] grant,
    output logic [2:0]   idx
);
    logic [N-1:0] rot;
    logic         found;
    int           pos;
    // rotate so the channel after ptr lands on bit 0, then take the lowest set bit
    always_comb begin
        rot   = N'({pend, pend} >> (ptr + 3'd1));
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = (int'(ptr) + 1 + k) % N;
            end
        end
        idx   = 3'(pos);
        grant = found ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/aviasales_rr.sv
// aviasales_rr: multi-channel seat booking engine with round-robin service and ack/nack responses
module aviasales_rr
    import aviasales_pkg::*;
#(
    parameter int SEATS = 16,
    parameter int NCH   = 2,
    parameter int SW_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req,
    input  logic [NCH-1:0]       op,
    input  logic [NCH*SW_W-1:0]  seat,
    input  logic                 lock,
    output logic                 ack,
    output logic                 nack,
    output logic [1:0]           status,
    output logic [2:0]           resp_ch,
    output logic                 busy,
    output logic                 full,
    output logic [8:0]           free_cnt,
    output logic [SEATS-1:0]     occ_map
);
    state_t              state_q, state_d;
    logic [NCH-1:0]      pend_q, pend_d, op_q, op_d, clr, take, grant;
    logic [NCH*SW_W-1:0] seat_q, seat_d;
    logic [2:0]          ptr_q, ptr_d, gidx;
    logic [SEATS-1:0]    occ_q, occ_d;
    logic [8:0]          free_q, free_d;
    logic                ack_q, ack_d, nack_q, nack_d;
    logic [1:0]          status_q, status_d;
    logic [2:0]          resp_ch_q, resp_ch_d;
    logic [SW_W-1:0]     cur_seat;
    logic                cur_op, cur_occ;

    rr_arbiter #(.N(NCH)) u_arb (
        .pend  (pend_q),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx)
    );

    // accept a request when its channel is idle or being released at this same edge
    always_comb begin
        take   = req & (~pend_q | clr);
        pend_d = (pend_q & ~clr) | take;
        op_d   = op_q;
        seat_d = seat_q;
        for (int i = 0; i < NCH; i++) begin
            if (take[i]) begin
                op_d[i]                = op[i];
                seat_d[i*SW_W +: SW_W] = seat[i*SW_W +: SW_W];
            end
        end
    end

    // grant, evaluate the held request against the bitmap, then pulse the response
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        occ_d     = occ_q;
        free_d    = free_q;
        ack_d     = 1'b0;
        nack_d    = 1'b0;
        status_d  = status_q;
        resp_ch_d = resp_ch_q;
        clr       = '0;
        cur_op    = 1'(op_q >> ptr_q);
        cur_seat  = SW_W'(seat_q >> (ptr_q * SW_W));
        cur_occ   = 1'(occ_q >> cur_seat);
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    ptr_d   = gidx;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d   = S_RESP;
                resp_ch_d = ptr_q;
                if (int'(cur_seat) >= SEATS) status_d = ST_BADSEAT;
                else if (cur_op == OP_BOOK && lock) status_d = ST_CLOSED;
                else if ((cur_op == OP_BOOK) != cur_occ) begin
                    status_d = ST_OK;
                    ack_d    = 1'b1;
                    occ_d    = occ_q ^ (SEATS'(1) << cur_seat);
                    free_d   = cur_op == OP_BOOK ? free_q - 9'd1 : free_q + 9'd1;
                end
                else status_d = ST_TAKEN;
                nack_d = !ack_d;
            end
            S_RESP: begin
                clr     = NCH'(1) << ptr_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // all state, cleared immediately on reset with the pointer parked so channel 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            op_q      <= '0;
            seat_q    <= '0;
            ptr_q     <= 3'(NCH - 1);
            occ_q     <= '0;
            free_q    <= 9'(SEATS);
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            status_q  <= ST_OK;
            resp_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            op_q      <= op_d;
            seat_q    <= seat_d;
            ptr_q     <= ptr_d;
            occ_q     <= occ_d;
            free_q    <= free_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
            status_q  <= status_d;
            resp_ch_q <= resp_ch_d;
        end
    end

    assign ack      = ack_q;
    assign nack     = nack_q;
    assign status   = status_q;
    assign resp_ch  = resp_ch_q;
    assign occ_map  = occ_q;
    assign free_cnt = free_q;
    assign full     = free_q == 9'd0;
    assign busy     = |pend_q || state_q != S_IDLE;
endmodule
